// File: rtl/data_wbuf_pkg.sv
// Shared definitions for the store write buffer: access-size codes, the
// downstream FSM encoding and the layout of one buffered store.
package data_wbuf_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;
    localparam int SIZE_W = 2;

    // cpu_size / mem_size encodings
    localparam logic [SIZE_W-1:0] SZ_BYTE = 2'd0;
    localparam logic [SIZE_W-1:0] SZ_HALF = 2'd1;
    localparam logic [SIZE_W-1:0] SZ_WORD = 2'd2;

    // Downstream port owner; one-hot so each state test is a single bit.
    typedef enum logic [3:0] {
        S_IDLE    = 4'b0001,
        S_LD_WAIT = 4'b0010,
        S_ST_REQ  = 4'b0100,
        S_ST_WAIT = 4'b1000
    } wbuf_state_e;

    // One buffered store, exactly as it will be replayed downstream.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [SIZE_W-1:0] size;
        logic [STRB_W-1:0] wstrb;
        logic [DATA_W-1:0] wdata;
    } wbuf_entry_t;

    // Two byte addresses fall in the same 32-bit word.
    function automatic logic same_word(input logic [ADDR_W-1:0] a,
                                       input logic [ADDR_W-1:0] b);
        return a[ADDR_W-1:2] == b[ADDR_W-1:2];
    endfunction

endpackage

// File: rtl/data_wbuf_fifo.sv
// Circular store FIFO for the write buffer. Besides push/pop it compares
// every live entry against a probe address in parallel so a load can be
// held off while an older store to the same word is still buffered.
import data_wbuf_pkg::*;

module wbuf_fifo #(
    parameter int DEPTH = 4
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              push,
    input  logic              pop,
    input  wbuf_entry_t       wr_entry,
    input  logic [ADDR_W-1:0] cmp_addr,
    output wbuf_entry_t       head,
    output logic              full,
    output logic              empty,
    output logic              hit
);

    localparam int PTR_W = $clog2(DEPTH);

    wbuf_entry_t        slots [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     count;
    logic [DEPTH-1:0]   live;
    logic [DEPTH-1:0]   match;

    assign full  = (count == (PTR_W+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = slots[rd_ptr];

    // Slot i is live when its distance from the head is below the occupancy;
    // the head stays live until it is popped, i.e. through the whole drain.
    always_comb begin
        live  = '0;
        match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            live[i]  = ({1'b0, PTR_W'(i) - rd_ptr} < count);
            match[i] = same_word(slots[i].addr, cmp_addr);
        end
        hit = |(live & match);
    end

    // Storage, wrapping pointers and occupancy; push and pop may share a cycle.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slots[i] <= '0;
            end
        end else begin
            if (push) begin
                slots[wr_ptr] <= wr_entry;
                wr_ptr        <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/data_wbuf.sv
// Store write buffer between the CPU data port and the AXI-SRAM converter.
// Stores are accepted into a FIFO and acknowledged on the next cycle, then
// drained in the background; loads go straight downstream once no buffered
// store targets the same word. Only one downstream transaction is ever in
// flight, so each mem_data_ok belongs to the current state unambiguously.
import data_wbuf_pkg::*;

module data_wbuf #(
    parameter int DEPTH = 4
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic [SIZE_W-1:0] cpu_size,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [STRB_W-1:0] cpu_wstrb,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_addr_ok,
    output logic              cpu_data_ok,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [SIZE_W-1:0] mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [STRB_W-1:0] mem_wstrb,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata
);

    wbuf_state_e state;
    logic        st_ack_q;

    wbuf_entry_t cpu_entry;
    wbuf_entry_t head;
    logic        fifo_full;
    logic        fifo_empty;
    logic        hazard;

    logic        in_idle;
    logic        in_ld_wait;
    logic        in_st_req;
    logic        in_st_wait;
    logic        pop;
    logic        ld_go;
    logic        st_acc;

    assign in_idle    = (state == S_IDLE);
    assign in_ld_wait = (state == S_LD_WAIT);
    assign in_st_req  = (state == S_ST_REQ);
    assign in_st_wait = (state == S_ST_WAIT);

    assign cpu_entry = '{addr: cpu_addr, size: cpu_size,
                         wstrb: cpu_wstrb, wdata: cpu_wdata};

    // The drained store retires on its response; that same cycle frees a
    // slot, so a store waiting on a full FIFO can be taken in the pop cycle.
    assign pop = in_st_wait & mem_data_ok;

    // Loads are offered downstream only from IDLE, with no pending store ack
    // (keeps data_ok pulses in order) and no older store to the same word.
    // Both request paths are gated by reset so all outputs read 0 in reset.
    assign ld_go  = aresetn & in_idle & cpu_req & ~cpu_wr & ~hazard & ~st_ack_q;
    assign st_acc = aresetn & cpu_req & cpu_wr & (~fifo_full | pop) & ~in_ld_wait;

    assign cpu_addr_ok = st_acc | (ld_go & mem_addr_ok);
    assign cpu_data_ok = st_ack_q | (in_ld_wait & mem_data_ok);
    assign cpu_rdata   = in_ld_wait ? mem_rdata : '0;

    wbuf_fifo #(
        .DEPTH    (DEPTH)
    ) u_fifo (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .push     (st_acc),
        .pop      (pop),
        .wr_entry (cpu_entry),
        .cmp_addr (cpu_addr),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .hit      (hazard)
    );

    // Downstream request mux: a pass-through load or the FIFO head.
    always_comb begin
        mem_req   = 1'b0;
        mem_wr    = 1'b0;
        mem_size  = '0;
        mem_addr  = '0;
        mem_wstrb = '0;
        mem_wdata = '0;
        if (ld_go) begin
            mem_req   = 1'b1;
            mem_size  = cpu_size;
            mem_addr  = cpu_addr;
            mem_wstrb = cpu_wstrb;
            mem_wdata = cpu_wdata;
        end else if (in_st_req) begin
            mem_req   = 1'b1;
            mem_wr    = 1'b1;
            mem_size  = head.size;
            mem_addr  = head.addr;
            mem_wstrb = head.wstrb;
            mem_wdata = head.wdata;
        end
    end

    // Downstream FSM and the one-cycle store acknowledge.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= S_IDLE;
            st_ack_q <= 1'b0;
        end else begin
            st_ack_q <= st_acc;
            case (state)
                S_IDLE: begin
                    // A presented load keeps the port until it is taken.
                    if (ld_go) begin
                        if (mem_addr_ok) begin
                            state <= S_LD_WAIT;
                        end
                    end else if (!fifo_empty) begin
                        state <= S_ST_REQ;
                    end
                end
                S_ST_REQ: begin
                    if (mem_addr_ok) begin
                        state <= S_ST_WAIT;
                    end
                end
                S_ST_WAIT: begin
                    if (mem_data_ok) begin
                        state <= S_IDLE;
                    end
                end
                S_LD_WAIT: begin
                    if (mem_data_ok) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_wbuf.sv
// Bench for data_wbuf: a responding memory model, a CPU-side scoreboard
// (store acks and load data in request order) and a write scoreboard
// (downstream stores in acceptance order), driven by a vector table and a
// few hand-written multi-cycle sequences.
`timescale 1ns/1ps
module tb_data_wbuf;
    import data_wbuf_pkg::*;

    localparam int DEPTH = 4;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        cpu_req;
    logic        cpu_wr;
    logic [1:0]  cpu_size;
    logic [31:0] cpu_addr;
    logic [3:0]  cpu_wstrb;
    logic [31:0] cpu_wdata;
    logic        cpu_addr_ok;
    logic        cpu_data_ok;
    logic [31:0] cpu_rdata;
    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    data_wbuf #(.DEPTH(DEPTH)) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .cpu_req     (cpu_req),
        .cpu_wr      (cpu_wr),
        .cpu_size    (cpu_size),
        .cpu_addr    (cpu_addr),
        .cpu_wstrb   (cpu_wstrb),
        .cpu_wdata   (cpu_wdata),
        .cpu_addr_ok (cpu_addr_ok),
        .cpu_data_ok (cpu_data_ok),
        .cpu_rdata   (cpu_rdata),
        .mem_req     (mem_req),
        .mem_wr      (mem_wr),
        .mem_size    (mem_size),
        .mem_addr    (mem_addr),
        .mem_wstrb   (mem_wstrb),
        .mem_wdata   (mem_wdata),
        .mem_addr_ok (mem_addr_ok),
        .mem_data_ok (mem_data_ok),
        .mem_rdata   (mem_rdata)
    );

    always #5 aclk = ~aclk;

    typedef struct { bit ld; logic [31:0] rdata; } cpu_exp_t;
    typedef struct { logic [31:0] addr; logic [1:0] size; logic [3:0] wstrb; logic [31:0] wdata; } wr_exp_t;
    typedef struct { bit wr; logic [1:0] sz; logic [31:0] a; logic [3:0] st; logic [31:0] d; logic [31:0] exp; } vec_t;

    cpu_exp_t cpu_q[$];
    wr_exp_t  wr_q[$];
    vec_t     vecs[6];

    int checks = 0;
    int errors = 0;

    // memory model state
    logic        mem_ready;
    int          lat;
    bit          m_busy;
    bit          m_is_wr;
    int          m_cnt;
    logic [31:0] m_rdata;

    int          cyc = 0;
    int          n_wr = 0;
    int          n_wr_done = 0;
    bit          last_acc;
    bit          last_dok;
    int          acc_cyc = 0;
    int          ld_dok_cyc = 0;
    int          ld_dok_wr = 0;
    logic [31:0] cur_exp;

    // Load data the memory model returns for an address.
    function automatic logic [31:0] pat(input logic [31:0] a);
        return 32'h1234_467A ^ a;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One clock: drive memory responses, sample just before the edge,
    // update scoreboards and the memory model, then return at the negedge.
    task automatic tick();
        cpu_exp_t e;
        wr_exp_t  w;
        mem_addr_ok = mem_ready & ~m_busy;
        mem_data_ok = m_busy && (m_cnt == 0);
        mem_rdata   = mem_data_ok ? m_rdata : 32'h0;
        #4;
        last_acc = cpu_req & cpu_addr_ok;
        last_dok = cpu_data_ok;
        if (cpu_data_ok) begin
            if (cpu_q.size() == 0) begin
                chk("spurious_data_ok", 1, 0);
            end else begin
                e = cpu_q.pop_front();
                if (e.ld) begin
                    chk("ld_rdata", cpu_rdata, e.rdata);
                    ld_dok_cyc = cyc;
                    ld_dok_wr  = n_wr_done;
                end else begin
                    chk("st_ack_rdata", cpu_rdata, 0);
                end
            end
        end
        if (last_acc) begin
            acc_cyc = cyc;
            if (cpu_wr) begin
                cpu_q.push_back('{ld: 1'b0, rdata: 32'h0});
                wr_q.push_back('{addr: cpu_addr, size: cpu_size, wstrb: cpu_wstrb, wdata: cpu_wdata});
            end else begin
                cpu_q.push_back('{ld: 1'b1, rdata: cur_exp});
            end
        end
        if (mem_data_ok) begin
            m_busy = 1'b0;
            if (m_is_wr) n_wr_done++;
        end else if (m_busy) begin
            m_cnt--;
        end
        if (mem_req && mem_addr_ok) begin
            if (mem_wr) begin
                n_wr++;
                if (wr_q.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    w = wr_q.pop_front();
                    chk("wr_addr", mem_addr, w.addr);
                    chk("wr_data", mem_wdata, w.wdata);
                    chk("wr_strb", {28'h0, mem_wstrb}, {28'h0, w.wstrb});
                    chk("wr_size", {30'h0, mem_size}, {30'h0, w.size});
                end
            end else begin
                chk("ld_addr", mem_addr, cpu_addr);
                chk("ld_accept", {31'h0, cpu_addr_ok}, 1);
            end
            m_busy  = 1'b1;
            m_is_wr = mem_wr;
            m_cnt   = lat;
            m_rdata = mem_wr ? 32'h0 : pat(mem_addr);
        end
        cyc++;
        @(negedge aclk);
    endtask

    task automatic issue(input bit wr, input logic [1:0] sz, input logic [31:0] a,
                         input logic [3:0] st, input logic [31:0] d,
                         input logic [31:0] exp, output int waited);
        cpu_req   = 1'b1;
        cpu_wr    = wr;
        cpu_size  = sz;
        cpu_addr  = a;
        cpu_wstrb = st;
        cpu_wdata = d;
        cur_exp   = exp;
        waited    = 0;
        tick();
        while (!last_acc && waited < 300) begin
            waited++;
            tick();
        end
        if (!last_acc) chk("issue_timeout", 0, 1);
        cpu_req = 1'b0;
        cpu_wr  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((cpu_q.size() != 0 || wr_q.size() != 0 || m_busy || dut.u_fifo.count != 0) && n < 400) begin
            tick();
            n++;
        end
        if (n >= 400) chk("drain_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int base;

        vecs[0] = '{wr: 1'b1, sz: SZ_WORD, a: 32'h0000_0040, st: 4'hF, d: 32'hCAFE_F00D, exp: 32'h0};
        vecs[1] = '{wr: 1'b1, sz: SZ_BYTE, a: 32'h0000_0041, st: 4'h2, d: 32'h0000_AB00, exp: 32'h0};
        vecs[2] = '{wr: 1'b0, sz: SZ_WORD, a: 32'h0000_0040, st: 4'h0, d: 32'h0,         exp: 32'h1234_463A};
        vecs[3] = '{wr: 1'b1, sz: SZ_HALF, a: 32'h0000_0102, st: 4'hC, d: 32'h5566_0000, exp: 32'h0};
        vecs[4] = '{wr: 1'b0, sz: SZ_HALF, a: 32'h0000_0102, st: 4'h0, d: 32'h0,         exp: 32'h1234_4778};
        vecs[5] = '{wr: 1'b0, sz: SZ_BYTE, a: 32'h0000_0FFF, st: 4'h0, d: 32'h0,         exp: 32'h1234_4985};

        // reset: requests present, responses asserted, outputs must stay 0
        aresetn = 1'b0;
        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_size = SZ_WORD;
        cpu_addr = 32'h1C00_0100; cpu_wstrb = 4'hF; cpu_wdata = 32'h1111_2222;
        mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        mem_ready = 1'b1; lat = 1; m_busy = 1'b0; m_is_wr = 1'b0; m_cnt = 0; m_rdata = 0;
        cur_exp = 0;
        #12;
        chk("rst_addr_ok", {31'h0, cpu_addr_ok}, 0);
        chk("rst_data_ok", {31'h0, cpu_data_ok}, 0);
        chk("rst_mem_req", {31'h0, mem_req}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_count", 32'(dut.u_fifo.count), 0);
        @(negedge aclk);
        cpu_req = 1'b0; cpu_wr = 1'b0;
        aresetn = 1'b1;

        // 1: single store, memory answers two cycles after the handshake
        mem_ready = 1'b1; lat = 1;
        base = n_wr;
        issue(1'b1, SZ_WORD, 32'h1C00_0100, 4'hF, 32'hDEAD_BEEF, 0, w);
        chk("t1_accept_wait", w, 0);
        tick();
        chk("t1_ack_next_cycle", {31'h0, last_dok}, 1);
        drain();
        chk("t1_writes", n_wr - base, 1);
        chk("t1_count", 32'(dut.u_fifo.count), 0);

        // table: isolated accesses, each accepted at once
        base = n_wr;
        for (int i = 0; i < 6; i++) begin
            issue(vecs[i].wr, vecs[i].sz, vecs[i].a, vecs[i].st, vecs[i].d, vecs[i].exp, w);
            chk("tbl_accept_wait", w, 0);
            drain();
        end
        chk("tbl_writes", n_wr - base, 3);

        // 2: fill with the memory stalled, fifth store waits for a pop
        mem_ready = 1'b0; lat = 1;
        base = n_wr;
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, SZ_WORD, 32'h9000 + 32'(4 * i), 4'hF, 32'hA000_0000 + 32'(i), 0, w);
            chk("t2_fill_wait", w, 0);
        end
        chk("t2_count_full", 32'(dut.u_fifo.count), 4);
        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_size = SZ_WORD;
        cpu_addr = 32'h9010; cpu_wstrb = 4'h3; cpu_wdata = 32'hA000_0004;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t2_full_stall", {31'h0, last_acc}, 0);
        end
        mem_ready = 1'b1;
        w = 0;
        tick();
        while (!last_acc && w < 50) begin
            w++;
            tick();
        end
        chk("t2_push_in_pop", {31'h0, mem_data_ok}, 1);
        cpu_req = 1'b0; cpu_wr = 1'b0;
        drain();
        chk("t2_writes", n_wr - base, 5);

        // 3: load to a word held behind another buffered store
        mem_ready = 1'b0; lat = 1;
        issue(1'b1, SZ_WORD, 32'h2000, 4'hF, 32'h0000_2000, 0, w);
        issue(1'b1, SZ_WORD, 32'h1000, 4'hF, 32'h0000_1000, 0, w);
        base = n_wr_done;
        mem_ready = 1'b1;
        issue(1'b0, SZ_HALF, 32'h1002, 4'h0, 32'h0, 32'h1234_5678, w);
        chk("t3_hazard_drained", n_wr_done - base, 2);
        drain();

        // 4: unrelated load overtakes the remaining buffered stores
        mem_ready = 1'b0; lat = 1;
        for (int i = 0; i < 3; i++) begin
            issue(1'b1, SZ_WORD, 32'h2000 + 32'(4 * i), 4'hF, 32'hB000_0000 + 32'(i), 0, w);
        end
        base = n_wr_done;
        mem_ready = 1'b1;
        issue(1'b0, SZ_WORD, 32'h3000, 4'h0, 32'h0, 32'h1234_767A, w);
        chk("t4_bypass_at_accept", n_wr_done - base, 1);
        drain();
        chk("t4_stores_pending_at_ld", ld_dok_wr - base, 1);

        // 5: store held off by an outstanding load, load held off by an ack
        mem_ready = 1'b1; lat = 3;
        issue(1'b0, SZ_WORD, 32'h4000, 4'h0, 32'h0, 32'h1234_067A, w);
        chk("t5_ld_wait", w, 0);
        issue(1'b1, SZ_WORD, 32'h5000, 4'hF, 32'h5555_0000, 0, w);
        chk("t5_st_after_ld", acc_cyc - ld_dok_cyc, 1);
        issue(1'b0, SZ_WORD, 32'h6000, 4'h0, 32'h0, 32'h1234_267A, w);
        chk("t5_ld_after_ack", {31'h0, w >= 1}, 1);
        drain();

        // 6: reset while a store drain is outstanding
        mem_ready = 1'b1; lat = 6;
        issue(1'b1, SZ_WORD, 32'h7000, 4'hF, 32'h7777_0000, 0, w);
        issue(1'b1, SZ_WORD, 32'h7004, 4'hF, 32'h7777_0004, 0, w);
        tick();
        tick();
        chk("t6_count_before", 32'(dut.u_fifo.count), 2);
        aresetn = 1'b0;
        #1;
        chk("t6_rst_mem_req", {31'h0, mem_req}, 0);
        chk("t6_rst_data_ok", {31'h0, cpu_data_ok}, 0);
        chk("t6_rst_count", 32'(dut.u_fifo.count), 0);
        @(negedge aclk);
        aresetn = 1'b1;
        wr_q.delete();
        cpu_q.delete();
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("t6_no_req", {31'h0, mem_req}, 0);
            chk("t6_no_data_ok", {31'h0, cpu_data_ok}, 0);
        end
        base = n_wr;
        lat = 1;
        issue(1'b1, SZ_WORD, 32'h8000, 4'hF, 32'h8888_0000, 0, w);
        chk("t6_store_after_rst", w, 0);
        drain();
        chk("t6_writes", n_wr - base, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_wbuf.md
Name: data_wbuf

Overview:
- Store write buffer between the CPU data-SRAM port (EXE/MEM stage) and the data port of the AXI-SRAM converter.
- Accepts stores immediately into a small FIFO and acknowledges them one cycle later.
- Drains stores to memory in the background.
- Passes loads straight through, after a word-address hazard check against buffered stores.
- Keeps at most one downstream transaction outstanding, so every downstream data_ok is attributed unambiguously.

Parameters:
DEPTH, 4, number of store entries (power of two, 2..16)
PTR_W, $clog2(DEPTH), FIFO pointer width (derived, not overridable)

Ports:
aclk  input  1  clock
aresetn  input  1  asynchronous active-low reset
cpu_req  input  1  CPU request valid
cpu_wr  input  1  1 = store, 0 = load
cpu_size  input  2  access size 0/1/2 = byte/half/word
cpu_addr  input  32  byte address
cpu_wstrb  input  4  store byte enables
cpu_wdata  input  32  store data
cpu_addr_ok  output  1  request accepted this cycle
cpu_data_ok  output  1  load data valid / store completed
cpu_rdata  output  32  load data
mem_req  output  1  downstream request valid
mem_wr  output  1  downstream store flag
mem_size  output  2  downstream size
mem_addr  output  32  downstream address
mem_wstrb  output  4  downstream byte enables
mem_wdata  output  32  downstream store data
mem_addr_ok  input  1  downstream request accepted
mem_data_ok  input  1  downstream response
mem_rdata  input  32  downstream load data

Behaviour:
- Clock and reset: one clock, aclk. aresetn is asynchronous, active-low. On assertion all flops clear immediately: FIFO empty, count 0, pointers 0, state IDLE, st_ack_q 0.
- Outputs while aresetn = 0: cpu_addr_ok 0, cpu_data_ok 0, mem_req 0, other outputs 0.
- Reset mid-operation drops buffered stores and any outstanding transaction. No acknowledge is issued afterwards.
- FIFO entry fields: addr[31:0], size[1:0], wstrb[3:0], wdata[31:0].
- Occupancy counter is PTR_W+1 bits wide. full = (count == DEPTH); empty = (count == 0).
- Pointers wrap modulo DEPTH. Simultaneous push and pop leaves count unchanged.
- Store accept:
  - cpu_addr_ok = cpu_req & cpu_wr & !full & (state != LD_WAIT). Combinational, same cycle.
  - On accept the entry is pushed and st_ack_q is set for one cycle.
  - cpu_data_ok for a store = st_ack_q, i.e. exactly 1 cycle after accept.
  - Full FIFO: cpu_addr_ok stays 0 until a pop frees an entry. Push in the pop cycle is allowed.
- Load hazard:
  - hazard = any valid entry with entry.addr[31:2] == cpu_addr[31:2].
  - The head entry counts as valid while it is in ST_REQ/ST_WAIT.
- Downstream FSM, states IDLE, LD_WAIT, ST_REQ, ST_WAIT:
  - IDLE with cpu_req & !cpu_wr & !hazard & !st_ack_q: drive mem_req = 1 with mem_wr = 0 and the cpu fields combinationally.
    - cpu_addr_ok = mem_addr_ok.
    - On handshake, go to LD_WAIT.
    - Loads have priority over draining.
  - IDLE otherwise, with FIFO non-empty: go to ST_REQ.
  - ST_REQ: mem_req = 1, mem_wr = 1, fields from the head entry, held stable until mem_addr_ok. Then go to ST_WAIT.
  - ST_WAIT: on mem_data_ok, pop the head and go to IDLE. No CPU-visible pulse.
  - LD_WAIT: cpu_data_ok = mem_data_ok and cpu_rdata = mem_rdata, both pass-through. On mem_data_ok go to IDLE.
- Ordering:
  - No store is accepted while a load is outstanding.
  - No load is accepted in the cycle a store acknowledge is pending.
  - Therefore CPU-visible data_ok pulses stay in request order and never coincide.
- A load hitting a buffered store stalls (cpu_addr_ok = 0) until the matching entries drain. There is no store-to-load forwarding.
- mem_data_ok in IDLE or ST_REQ is ignored.
- cpu_rdata = 0 when not in LD_WAIT.

Decomposition:
- Shared package: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), the FSM state encoding (one-hot, 4 bits), and the entry field widths.
- One sub-module is natural: wbuf_fifo.
  - Parameterised DEPTH.
  - push/pop/full/empty/head outputs.
  - Parallel per-entry word-address compare producing a hit output.
- The FSM and the ack register stay in data_wbuf.

Test Plan:
1. Single store: addr 0x1C000100, wdata 0xDEADBEEF, wstrb 0xF; mem_addr_ok and mem_data_ok responding after 2 cycles -> cpu_addr_ok same cycle, cpu_data_ok at +1, downstream write to 0x1C000100 observed, count back to 0.
2. Fill: 5 back-to-back stores with DEPTH=4 and mem_addr_ok held 0 -> first 4 accepted, 5th stalls (cpu_addr_ok=0). Release mem_addr_ok/mem_data_ok -> 5th accepted in the pop cycle; writes appear in order, pointers wrap.
3. Load hazard: store to 0x1000 buffered, then load 0x1002 -> load stalls until the store's mem_data_ok, then issues with mem_addr 0x1002 and returns mem_rdata 0x12345678 on cpu_rdata with cpu_data_ok.
4. Load bypass: 3 stores to 0x2000/0x2004/0x2008 buffered, then load 0x3000 -> load issued before the remaining drains; stores stay pending until load data_ok.
5. Ordering: load outstanding, store request presented -> cpu_addr_ok=0 until load data_ok; store accepted the cycle after; data_ok pulses never coincide.
6. Reset in ST_WAIT with 2 entries buffered: aresetn low for 1 cycle -> mem_req and cpu_data_ok 0 immediately, count 0, a late mem_data_ok is ignored, a subsequent store works normally.
